sequence_key_gen_param: RTL

Parametrised puzzle-sequence generator for the bomb-defuse game. An internal free-running LFSR supplies entropy. On request it builds a key of up to DIGITS decimal digits, with the length set by the current level. It then presents the key to the seven-segment display and comparator path with a transmit/ack handshake, and adds length scaling, digit range folding and a no-adjacent-repeat rule.

---
 rtl/sequence_key_gen_param.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sequence_key_gen_param.sv
// sequence_key_gen_param
// Puzzle-sequence generator for the bomb-defuse game. A free-running
// Fibonacci LFSR supplies entropy. An accepted request builds a key of
// len = min(level_state+1, DIGITS) decimal digits, one digit per clock.
// Out-of-range values are folded back into 0..DIGIT_MAX, and a digit equal
// to its predecessor is bumped. The finished key is then presented on
// sequence_key/key_len.
//
// Handshake: transmit rises on the edge that writes the last digit and holds
// sequence_key/key_len stable until key_ack is sampled high on a later edge.
// key_ack is ignored unless transmit is high. gen_req is ignored while busy.
// Dropping game_state in BUILD or HOLD aborts to IDLE with a blank key. The
// abort wins over key_ack and over completion of the key.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   game_state   1 = game running, 0 aborts generation
//   level_state  current level, sampled when a request is accepted
//   gen_req      single-cycle request for a new key
//   key_ack      consumer has taken the key
//   sequence_key digit i at [i*DIGIT_W +: DIGIT_W], digit 0 generated first
//   key_len      number of valid digits
//   transmit     key valid, held until acknowledged
//   busy         high while building or holding a key
module sequence_key_gen_param #(
  parameter int                   LFSR_W    = 8,
  parameter logic [LFSR_W-1:0]    LFSR_TAPS = 8'hB8,
  parameter logic [LFSR_W-1:0]    LFSR_SEED = 8'hA5,
  parameter int                   DIGITS    = 4,
  parameter int                   DIGIT_W   = 4,
  parameter int                   DIGIT_MAX = 9,
  parameter logic [DIGIT_W-1:0]   BLANK     = 4'hF,
  parameter int                   LEVEL_W   = 2,
  localparam int                  LEN_W     = $clog2(DIGITS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        game_state,
  input  logic [LEVEL_W-1:0]          level_state,
  input  logic                        gen_req,
  input  logic                        key_ack,
  output logic [DIGITS*DIGIT_W-1:0]   sequence_key,
  output logic [LEN_W-1:0]            key_len,
  output logic                        transmit,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [DIGIT_W-1:0]        DMAX      = DIGIT_W'(DIGIT_MAX);
  localparam logic [DIGIT_W-1:0]        DMAX_P1   = DIGIT_W'(DIGIT_MAX + 1);
  localparam logic [DIGITS*DIGIT_W-1:0] ALL_BLANK = {DIGITS{BLANK}};

  state_t                      state_q, state_d;
  logic [LFSR_W-1:0]           lfsr_q, lfsr_d;
  logic [DIGITS*DIGIT_W-1:0]   key_q, key_d;
  logic [LEN_W-1:0]            len_q, len_d;
  logic [LEN_W-1:0]            cnt_q, cnt_d;
  logic [DIGIT_W-1:0]          prev_q, prev_d;
  logic [LEN_W-1:0]            key_len_q, key_len_d;

  logic [DIGIT_W-1:0]          raw;
  logic [DIGIT_W-1:0]          folded;
  logic [DIGIT_W-1:0]          digit;
  logic [LEN_W-1:0]            req_len;
  logic                        last_digit;

  // The all-zero state is a lock-up state for an XOR LFSR, so it reloads
  // the seed instead of shifting.
  always_comb begin
    if (lfsr_q == '0) begin
      lfsr_d = LFSR_SEED;
    end else begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  // One subtraction is enough to fold because 2^DIGIT_W <= 2*(DIGIT_MAX+1).
  // prev_q starts at BLANK, which is above DIGIT_MAX, so the first digit
  // never bumps.
  always_comb begin
    raw    = lfsr_q[DIGIT_W-1:0];
    folded = (raw > DMAX) ? raw - DMAX_P1 : raw;
    if (folded == prev_q) begin
      digit = (folded == DMAX) ? '0 : folded + 1'b1;
    end else begin
      digit = folded;
    end
  end

  always_comb begin
    int lvl_p1;
    lvl_p1  = int'(level_state) + 1;
    req_len = (lvl_p1 > DIGITS) ? LEN_W'(DIGITS) : LEN_W'(lvl_p1);
  end

  assign last_digit = (cnt_q == len_q - 1'b1);

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    prev_d    = prev_q;
    key_len_d = key_len_q;
    case (state_q)
      IDLE: begin
        if (gen_req && game_state) begin
          state_d   = BUILD;
          len_d     = req_len;
          key_d     = ALL_BLANK;
          cnt_d     = '0;
          prev_d    = BLANK;
          key_len_d = '0;
        end
      end
      BUILD: begin
        if (!game_state) begin
          state_d   = IDLE;
          key_d     = ALL_BLANK;
          key_len_d = '0;
        end else begin
          for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == LEN_W'(i)) key_d[i*DIGIT_W +: DIGIT_W] = digit;
          end
          prev_d = digit;
          cnt_d  = cnt_q + 1'b1;
          if (last_digit) begin
            state_d   = HOLD;
            key_len_d = len_q;
          end
        end
      end
      HOLD: begin
        if (!game_state) begin
          state_d   = IDLE;
          key_d     = ALL_BLANK;
          key_len_d = '0;
        end else if (key_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      key_q     <= ALL_BLANK;
      len_q     <= '0;
      cnt_q     <= '0;
      prev_q    <= BLANK;
      key_len_q <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      key_q     <= key_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      prev_q    <= prev_d;
      key_len_q <= key_len_d;
    end
  end

  assign sequence_key = key_q;
  assign key_len      = key_len_q;
  assign transmit     = (state_q == HOLD);
  assign busy         = (state_q != IDLE);

endmodule
